// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types for the round-robin grant arbiter.
// Holds the FSM state encoding used by the top and exposed on the debug port.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Port bundle between requesters and the round-robin grant arbiter.
// Carries requests, release and grant outputs, plus debug visibility of FSM state and pointer.
interface rr_grant_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  import arb_pkg::*;

  localparam int IW = $clog2(NUM_PORTS);

  // Level protocol, not valid/ready: a requester holds its req_i bit until it
  // sees its gnt_o bit. The owner pulses release_i for one cycle to hand the
  // grant back. release_i is ignored while busy_o is low.
  logic [NUM_PORTS-1:0] req_i;
  logic                 release_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic [IW-1:0]        gnt_id_o;
  logic                 busy_o;
  logic                 preempt_o;
  arb_state_e           dbg_state_o;
  logic [IW-1:0]        dbg_ptr_o;

  modport master (
    output req_i, release_i,
    input  gnt_o, gnt_id_o, busy_o, preempt_o, dbg_state_o, dbg_ptr_o
  );

  modport slave (
    input  req_i, release_i,
    output gnt_o, gnt_id_o, busy_o, preempt_o, dbg_state_o, dbg_ptr_o
  );

endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin picker: the first set candidate at or above the
// pointer, wrapping around. It rotates by the pointer, priority-encodes, then rotates back.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         cand_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);
  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic           found;

  always_comb begin
    dbl   = {cand_i, cand_i};
    rot   = N'(dbl >> ptr_i);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
    // Undo the rotation; N need not be a power of two, so wrap explicitly.
    sum = {1'b0, off} + {1'b0, ptr_i};
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    valid_o  = |cand_i;
    idx_o    = valid_o ? sum[IW-1:0] : '0;
    onehot_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, which is held until release or hold timeout.
// It drives the select of a downstream one-hot mux, so the grant is always one-hot or zero.
module rr_grant_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_grant_arbiter_if.slave  arb
);
  import arb_pkg::*;

  localparam int IW = $clog2(NUM_PORTS);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        id_q, id_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 busy_q, busy_d;

  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] others;
  logic [NUM_PORTS-1:0] win_oh;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        ptr_next;
  logic                 win_valid;
  logic                 timeout;
  logic                 handover;
  logic                 preempt;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .cand_i   (cand),
    .ptr_i    (ptr_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  assign ptr_next = (win_idx == IW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    cand     = arb.req_i;
    handover = 1'b0;
    preempt  = 1'b0;
    others   = arb.req_i & ~gnt_q;
    timeout  = (hold_q == HW'(MAX_HOLD)) && (|others);

    case (state_q)
      ARB_IDLE: begin
        handover = 1'b1;
      end
      ARB_GRANT: begin
        // The pointer already sits past the owner, so a release makes the owner the lowest priority.
        if (arb.release_i) begin
          handover = 1'b1;
        end else if (timeout) begin
          preempt  = 1'b1;
          cand     = others;
          handover = 1'b1;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (handover) begin
      if (win_valid) begin
        gnt_d   = win_oh;
        id_d    = win_idx;
        ptr_d   = ptr_next;
        hold_d  = HW'(1);
        state_d = ARB_GRANT;
      end else begin
        gnt_d   = '0;
        id_d    = '0;
        hold_d  = '0;
        state_d = ARB_IDLE;
      end
    end

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign arb.gnt_o       = gnt_q;
  assign arb.gnt_id_o    = id_q;
  assign arb.busy_o      = busy_q;
  assign arb.preempt_o   = preempt && !reset;
  assign arb.dbg_state_o = state_q;
  assign arb.dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios then random traffic,
// checked against an owner/pointer/hold-count reference model.
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  localparam int NP = 4;
  localparam int MH = 8;

  logic clk;
  logic reset;

  rr_grant_arbiter_if #(.NUM_PORTS(NP)) bus ();

  rr_grant_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: who owns the grant, where the priority scan starts, cycles held
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  logic last_pre;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] cand, input int p);
    for (int k = 0; k < NP; k++) begin
      if (cand[(p + k) % NP]) return (p + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] others_of(input logic [NP-1:0] req);
    logic [NP-1:0] m;
    m = '0;
    if (m_owner >= 0) m[m_owner] = 1'b1;
    return req & ~m;
  endfunction

  function automatic logic model_preempt(input logic [NP-1:0] req, input logic rel, input logic rst);
    return !rst && (m_owner >= 0) && !rel && (m_hold == MH) && (others_of(req) != '0);
  endfunction

  task automatic model_handover(input int w);
    if (w >= 0) begin
      m_owner = w;
      m_ptr   = (w + 1) % NP;
      m_hold  = 1;
    end else begin
      m_owner = -1;
      m_hold  = 0;
    end
  endtask

  task automatic model_update(input logic [NP-1:0] req, input logic rel, input logic rst);
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      if (req != '0) model_handover(pick(req, m_ptr));
    end else if (rel) begin
      model_handover(pick(req, m_ptr));
    end else if (model_preempt(req, rel, rst)) begin
      model_handover(pick(others_of(req), m_ptr));
    end else if (m_hold < MH) begin
      m_hold++;
    end
  endtask

  // driver: apply inputs for one cycle, check preempt before the edge, outputs after
  task automatic step(input logic [NP-1:0] req, input logic rel, input logic rst);
    logic [NP-1:0] eg;
    reset         = rst;
    bus.req_i     = req;
    bus.release_i = rel;
    #3;
    last_pre = bus.preempt_o;
    chk("preempt", 32'(bus.preempt_o), 32'(model_preempt(req, rel, rst)));
    model_update(req, rel, rst);
    @(posedge clk);
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("gnt",   32'(bus.gnt_o),    32'(eg));
    chk("gnt_id", 32'(bus.gnt_id_o), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("busy",  32'(bus.busy_o),   32'(m_owner >= 0));
    chk("ptr",   32'(bus.dbg_ptr_o), 32'(m_ptr));
    chk("state", 32'(bus.dbg_state_o), (m_owner >= 0) ? 32'(ARB_GRANT) : 32'(ARB_IDLE));
  endtask

  initial begin
    reset = 1'b1;
    bus.req_i = '0;
    bus.release_i = 1'b0;

    // reset then idle
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_ptr", 32'(bus.dbg_ptr_o), 32'd0);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);

    // first grant from idle and back-to-back hand-over
    step(4'b1010, 1'b0, 1'b0);
    chk("first_gnt", 32'(bus.gnt_o), 32'h2);
    chk("first_id", 32'(bus.gnt_id_o), 32'd1);
    step(4'b1010, 1'b1, 1'b0);
    chk("b2b_gnt", 32'(bus.gnt_o), 32'h8);
    step(4'b0000, 1'b1, 1'b0);
    chk("release_idle", 32'(bus.gnt_o), 32'd0);

    // rotation with all requesting, release every 2nd cycle
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    chk("rot_first", 32'(bus.gnt_o), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("rot_hold", 32'(bus.gnt_o), 32'(1 << (k % NP)));
      step(4'b1111, 1'b1, 1'b0);
      chk("rot_next", 32'(bus.gnt_o), 32'(1 << ((k + 1) % NP)));
    end

    // hold timeout pre-emption
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0);
    chk("tmo_first", 32'(bus.gnt_o), 32'h1);
    for (int i = 0; i < MH - 1; i++) step(4'b0011, 1'b0, 1'b0);
    chk("tmo_before", 32'(bus.gnt_o), 32'h1);
    step(4'b0011, 1'b0, 1'b0);
    chk("tmo_pulse", 32'(last_pre), 32'd1);
    chk("tmo_gnt", 32'(bus.gnt_o), 32'h2);
    step(4'b0011, 1'b0, 1'b0);
    chk("tmo_one_cycle", 32'(last_pre), 32'd0);

    // single requester holds indefinitely, then re-granted to itself
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b0100, 1'b0, 1'b0);
    chk("solo_hold", 32'(bus.gnt_o), 32'h4);
    step(4'b0100, 1'b1, 1'b0);
    chk("solo_regrant", 32'(bus.gnt_o), 32'h4);

    // reset mid-grant
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    chk("pre_rst_gnt", 32'(bus.gnt_o), 32'h8);
    step(4'b1000, 1'b0, 1'b1);
    chk("mid_rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("mid_rst_ptr", 32'(bus.dbg_ptr_o), 32'd0);
    step(4'b1001, 1'b0, 1'b0);
    chk("post_rst_gnt", 32'(bus.gnt_o), 32'h1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 120) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
